// File: rtl/irq_pend_ctrl8.sv
// Interrupt pending/handshake controller for 8 sources. It latches rising request edges,
// presents the masked pending vector to an external priority encoder, and serves one index at a time over irq/ack.
module irq_pend_ctrl8 #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req_in,
  input  logic [7:0] mask,
  output logic [7:0] pend_out,
  input  logic [2:0] enc_y,
  input  logic       enc_idle,
  output logic       irq,
  output logic [2:0] vec,
  input  logic       ack,
  output logic       busy,
  output logic       timeout_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] pending_q, pending_d;
  logic [7:0] req_prev_q, req_prev_d;
  logic [2:0] vec_q, vec_d;
  logic [7:0] cnt_q, cnt_d;
  logic       timeout_err_q, timeout_err_d;
  logic [7:0] rise, clr;

  // NOTE: every signal gets a default at the top of the block, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    vec_d         = vec_q;
    cnt_d         = cnt_q;
    timeout_err_d = 1'b0;
    clr           = 8'h00;
    req_prev_d    = req_in;
    rise          = req_in & ~req_prev_q;

    unique case (state_q)
      IDLE: begin
        if (!enc_idle) begin
          vec_d   = enc_y;
          cnt_d   = 8'd0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // An ack wins over a timeout that falls in the same cycle.
        if (ack) begin
          clr     = 8'b1 << vec_q;
          state_d = GAP;
        end else if (cnt_q == CNT_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = GAP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // If a new edge and the clear hit the same bit, the set wins.
    pending_d = (pending_q & ~clr) | rise;
  end

  // NOTE: state registers use non-blocking assignments, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pending_q     <= 8'h00;
      req_prev_q    <= req_in;
      vec_q         <= 3'd0;
      cnt_q         <= 8'd0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      req_prev_q    <= req_prev_d;
      vec_q         <= vec_d;
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign pend_out    = pending_q & ~mask;
  assign irq         = (state_q == ISSUE);
  assign busy        = (state_q != IDLE);
  assign vec         = vec_q;
  assign timeout_err = timeout_err_q;

endmodule
